multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for a multicycle RV32I-subset datapath.
// Write strobes and Illegal are gated off combinationally while rst is high.
module multicycle_control_unit #(
    parameter int unsigned width  = 32,
    parameter bit          BNE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] Instr,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Illegal
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StBranch
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e     r_state;
    state_e     w_next;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_take;
    logic       w_branch_ok;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_unused_instr;

    assign w_opcode       = Instr[6:0];
    assign w_funct3       = Instr[14:12];
    assign w_unused_instr = ^{Instr[width-1:31], Instr[29:15], Instr[11:7]};
    assign w_branch_ok    = (w_funct3 == 3'b000) || (BNE_EN && (w_funct3 == 3'b001));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = StFetch;
        w_alu_op    = 2'b00;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        unique case (r_state)
            StFetch: begin
                w_ir_write  = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (w_opcode)
                    OpLoad, OpStore: w_next = StMemAdr;
                    OpRType:         w_next = StExecR;
                    OpIType:         w_next = StExecI;
                    OpJal:           w_next = StJal;
                    OpBranch: begin
                        if (w_branch_ok) begin
                            w_next = StBranch;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default:         w_illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = Instr[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                w_next = StMemWb;
            end
            StMemWb: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            StMemWrite: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            StExecR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                w_next   = StAluWb;
            end
            StExecI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = StAluWb;
            end
            StAluWb: begin
                w_reg_write = 1'b1;
            end
            StJal: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = StAluWb;
            end
            StBranch: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            default: w_next = StFetch;
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_take = Zero;
            3'b001:  w_take = ~Zero;
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        case (w_opcode)
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (w_funct3)
                    3'b000:  ALUControl = (Instr[5] & Instr[30]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Reset can land mid-instruction, so architectural side effects are masked here.
    assign PCWrite  = ~rst & (w_pc_update | (w_branch & w_take));
    assign IRWrite  = ~rst & w_ir_write;
    assign MemWrite = ~rst & w_mem_write;
    assign RegWrite = ~rst & w_reg_write;
    assign Illegal  = ~rst & w_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-state output vectors for each instruction class.
// A second instance with BNE_EN=0 covers the disabled-bne decode.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Instr = 32'h0;
    logic        Zero = 1'b0;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, Illegal2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
    logic [2:0] ALUControl2;

    logic [16:0] obs, obs2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.width(32), .BNE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    multicycle_control_unit #(.width(32), .BNE_EN(1'b0)) dut_nobne (
        .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .RegWrite(RegWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .ImmSrc(ImmSrc2), .ALUControl(ALUControl2), .Illegal(Illegal2)
    );

    assign obs  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, ALUControl, Illegal};
    assign obs2 = {PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, ResultSrc2, ALUSrcA2,
                   ALUSrcB2, ImmSrc2, ALUControl2, Illegal2};

    function automatic logic [16:0] mk(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, asa, asb, imm,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, asa, asb, imm, alu, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic [1:0] imm);
        return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction
    function automatic logic [16:0] e_decode(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    endfunction
    function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
        return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction

    // Inputs are changed at posedge+1 and sampled at posedge+2.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (obs !== mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0)) begin
            failures++;
            $display("FAIL reset_forced: got %h want %h", obs,
                     mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== e_fetch(2'b00)) begin
            failures++;
            $display("FAIL reset_fetch: got %h want %h", obs, e_fetch(2'b00));
        end
    endtask

    task automatic test_load_store();
        logic [16:0] e [2][5];
        logic [31:0] ins [2];
        int          len [2];
        ins[0] = 32'h00812283; len[0] = 5;
        e[0][0] = e_fetch(2'b00);
        e[0][1] = e_decode(2'b00);
        e[0][2] = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        e[0][3] = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e[0][4] = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        ins[1] = 32'h0050A423; len[1] = 4;
        e[1][0] = e_fetch(2'b01);
        e[1][1] = e_decode(2'b01);
        e[1][2] = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
        e[1][3] = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        e[1][4] = '0;
        for (int k = 0; k < 2; k++) begin
            Instr = ins[k];
            #1;
            for (int i = 0; i < len[k]; i++) begin
                if (i != 0) next_cycle();
                checks++;
                if (obs !== e[k][i]) begin
                    failures++;
                    $display("FAIL ldst_%0d_cyc%0d: got %h want %h", k, i, obs, e[k][i]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_exec_jal();
        logic [16:0] e [3][4];
        logic [31:0] ins [3];
        ins[0] = 32'h402081B3;
        e[0][2] = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
        e[0][3] = e_aluwb(2'b00);
        ins[1] = 32'h00108193;
        e[1][2] = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        e[1][3] = e_aluwb(2'b00);
        ins[2] = 32'h008000EF;
        e[2][2] = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
        e[2][3] = e_aluwb(2'b11);
        e[0][0] = e_fetch(2'b00); e[0][1] = e_decode(2'b00);
        e[1][0] = e_fetch(2'b00); e[1][1] = e_decode(2'b00);
        e[2][0] = e_fetch(2'b11); e[2][1] = e_decode(2'b11);
        for (int k = 0; k < 3; k++) begin
            Instr = ins[k];
            #1;
            for (int i = 0; i < 4; i++) begin
                if (i != 0) next_cycle();
                checks++;
                if (obs !== e[k][i]) begin
                    failures++;
                    $display("FAIL exec_%0d_cyc%0d: got %h want %h", k, i, obs, e[k][i]);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu_funct3();
        logic [31:0] ins [7];
        logic [2:0]  alu [7];
        logic        is_i [7];
        ins[0] = 32'h0020A1B3; alu[0] = 3'b101; is_i[0] = 0;  // slt
        ins[1] = 32'h0020C1B3; alu[1] = 3'b100; is_i[1] = 0;  // xor
        ins[2] = 32'h0020E1B3; alu[2] = 3'b011; is_i[2] = 0;  // or
        ins[3] = 32'h0020F1B3; alu[3] = 3'b010; is_i[3] = 0;  // and
        ins[4] = 32'h002091B3; alu[4] = 3'b000; is_i[4] = 0;  // sll: unlisted funct3
        ins[5] = 32'h40108193; alu[5] = 3'b000; is_i[5] = 1;  // addi with bit30 set
        ins[6] = 32'h002081B3; alu[6] = 3'b000; is_i[6] = 0;  // add
        for (int k = 0; k < 7; k++) begin
            logic [16:0] ex;
            ex = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, is_i[k] ? 2'b01 : 2'b00, 2'b00, alu[k], 0);
            Instr = ins[k];
            #1;
            next_cycle();
            next_cycle();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL alu_%0d: got %h want %h", k, obs, ex);
            end
            next_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4];
        logic        z [4];
        logic        pcw [4];
        ins[0] = 32'h00208463; z[0] = 1; pcw[0] = 1;
        ins[1] = 32'h00208463; z[1] = 0; pcw[1] = 0;
        ins[2] = 32'h00209463; z[2] = 1; pcw[2] = 0;
        ins[3] = 32'h00209463; z[3] = 0; pcw[3] = 1;
        for (int k = 0; k < 4; k++) begin
            logic [16:0] ex;
            ex = mk(pcw[k], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
            Instr = ins[k];
            Zero = z[k];
            #1;
            next_cycle();
            next_cycle();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL branch_%0d: got %h want %h", k, obs, ex);
            end
            next_cycle();
            checks++;
            if (obs !== e_fetch(2'b10)) begin
                failures++;
                $display("FAIL branch_%0d_refetch: got %h want %h", k, obs, e_fetch(2'b10));
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        logic [1:0]  imm [2];
        ins[0] = 32'h0000007F; imm[0] = 2'b00;
        ins[1] = 32'h0020C463; imm[1] = 2'b10;  // blt: branch funct3 not supported
        for (int k = 0; k < 2; k++) begin
            logic [16:0] ex;
            ex = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm[k], 3'b000, 1);
            Instr = ins[k];
            #1;
            next_cycle();
            checks++;
            if (obs !== ex) begin
                failures++;
                $display("FAIL illegal_%0d_decode: got %h want %h", k, obs, ex);
            end
            next_cycle();
            checks++;
            if (obs !== e_fetch(imm[k])) begin
                failures++;
                $display("FAIL illegal_%0d_refetch: got %h want %h", k, obs, e_fetch(imm[k]));
            end
        end
    endtask

    task automatic test_reset_mid_memwrite();
        logic [16:0] ex;
        Instr = 32'h0050A423;
        #1;
        next_cycle();
        next_cycle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        ex = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL rst_memwrite: got %h want %h", obs, ex);
        end
        @(posedge clk);
        #1;
        ex = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        checks++;
        if (obs !== ex) begin
            failures++;
            $display("FAIL rst_fetch_forced: got %h want %h", obs, ex);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== e_fetch(2'b01)) begin
            failures++;
            $display("FAIL rst_fetch_release: got %h want %h", obs, e_fetch(2'b01));
        end
    endtask

    task automatic test_bne_disabled();
        logic [16:0] ex2;
        Instr = 32'h00209463;
        #1;
        next_cycle();
        ex2 = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1);
        checks++;
        if (obs2 !== ex2) begin
            failures++;
            $display("FAIL bne_disabled_decode: got %h want %h", obs2, ex2);
        end
        checks++;
        if (obs !== e_decode(2'b10)) begin
            failures++;
            $display("FAIL bne_enabled_decode: got %h want %h", obs, e_decode(2'b10));
        end
        next_cycle();
        checks++;
        if (obs2 !== e_fetch(2'b10)) begin
            failures++;
            $display("FAIL bne_disabled_refetch: got %h want %h", obs2, e_fetch(2'b10));
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_exec_jal();
        test_alu_funct3();
        test_branch();
        test_illegal();
        test_reset_mid_memwrite();
        test_bne_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
